// File: rtl/debug_host_master_pkg.sv
// Shared constants and types for the UART debug protocol host.
// Optional RX inactivity timeout is enabled by defining DEBUG_HOST_RX_TIMEOUT_EN.
package debug_host_master_pkg;

  localparam int unsigned NB_CMD = 8;

  localparam logic [NB_CMD-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_CMD-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_CMD-1:0] CMD_STEP = 8'h53;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_CMD  = 3'd1,
    TX_LEN  = 3'd2,
    FETCH   = 3'd3,
    TX_WORD = 3'd4,
    TX_EXEC = 3'd5,
    RX_DUMP = 3'd6,
    FINISH  = 3'd7
  } host_state_e;

  // Dump is PC, then the register bank, then data memory.
  function automatic int unsigned dump_words(input int unsigned n_regs,
                                             input int unsigned n_dm);
    return 1 + n_regs + n_dm;
  endfunction

endpackage

// File: rtl/debug_host_master_if.sv
// Session control, program source, UART and dump-output signals of the debug host.
interface debug_host_master_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_ADDR = 8
);

  logic               i_cmd_start;
  logic               i_cmd_step;
  logic [NB_ADDR-1:0] i_prog_len;
  logic [NB_ADDR-1:0] o_prog_addr;
  logic [NB_DATA-1:0] i_prog_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_word;
  logic               o_word_valid;
  logic [7:0]         o_word_idx;
  logic               o_busy;
  logic               o_done;
  logic               o_error;

  modport master (
    input  i_cmd_start, i_cmd_step, i_prog_len, i_prog_data,
           i_tx_done, i_rx_data, i_rx_done,
    output o_prog_addr, o_tx_data, o_tx_start, o_word, o_word_valid,
           o_word_idx, o_busy, o_done, o_error
  );

  modport slave (
    output i_cmd_start, i_cmd_step, i_prog_len, i_prog_data,
           i_tx_done, i_rx_data, i_rx_done,
    input  o_prog_addr, o_tx_data, o_tx_start, o_word, o_word_valid,
           o_word_idx, o_busy, o_done, o_error
  );

endinterface

// File: rtl/debug_word_deser.sv
// MSB-first byte-to-word assembler with a running word index and one-cycle valid strobe.
module debug_word_deser #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8,
  parameter int unsigned NB_IDX  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               byte_valid_i,
  input  logic [NB_BYTE-1:0] byte_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o,
  output logic [NB_IDX-1:0]  word_idx_o
);

  localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BCNT = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned NB_ACC  = NB_DATA - NB_BYTE;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);

  // Only the leading bytes of a word need holding; the last byte completes it directly.
  logic [NB_ACC-1:0]  acc_q, acc_d;
  logic [NB_DATA-1:0] acc_shift_c;
  logic [NB_BCNT-1:0] bcnt_q, bcnt_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic               valid_q, valid_d;
  logic [NB_IDX-1:0]  word_idx_q, word_idx_d;

  assign acc_shift_c = {acc_q, byte_i};

  always_comb begin
    acc_d      = acc_q;
    bcnt_d     = bcnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    word_idx_d = word_idx_q;
    if (clr_i) begin
      acc_d  = '0;
      bcnt_d = '0;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      acc_d = acc_shift_c[NB_ACC-1:0];
      if (bcnt_q == LAST_BYTE) begin
        bcnt_d     = '0;
        word_d     = acc_shift_c;
        valid_d    = 1'b1;
        word_idx_d = idx_q;
        idx_d      = idx_q + NB_IDX'(1);
      end else begin
        bcnt_d = bcnt_q + NB_BCNT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      bcnt_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      word_idx_q <= '0;
    end else begin
      acc_q      <= acc_d;
      bcnt_q     <= bcnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      word_idx_q <= word_idx_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign word_idx_o   = word_idx_q;

endmodule

// File: rtl/debug_host_master.sv
// Host side of the UART debug protocol: program download, RUN/STEP, dump reassembly.
// Defining DEBUG_HOST_RX_TIMEOUT_EN adds an RX inactivity timeout that raises o_error.
module debug_host_master
  import debug_host_master_pkg::*;
#(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned NB_BYTE    = 8,
  parameter int unsigned NB_ADDR    = 8,
  parameter int unsigned N_REGS     = 32,
  parameter int unsigned N_DM_WORDS = 16
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  debug_host_master_if.master  bus
);

  localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BCNT = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned NB_WCNT = NB_ADDR + 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [7:0] LAST_IDX = 8'(dump_words(N_REGS, N_DM_WORDS) - 1);

  host_state_e        state_q;
  logic               step_q;
  logic [NB_ADDR-1:0] len_q;
  // One extra bit so a full-range length compares before the counter can wrap.
  logic [NB_WCNT-1:0] word_cnt_q;
  logic [NB_WCNT-1:0] wcnt_nxt_c;
  logic [NB_BCNT-1:0] byte_cnt_q;
  logic [NB_DATA-1:0] shreg_q;
  logic               tx_pend_q;
  logic               fetch_wait_q;
  logic [NB_BYTE-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               done_q;

  logic               tx_state_c;
  logic [NB_BYTE-1:0] send_byte_c;
  logic               tx_ack_c;
  logic               sess_start_c;
  logic               rx_byte_c;
  logic               word_valid_c;
  logic [7:0]         word_idx_c;

`ifdef DEBUG_HOST_RX_TIMEOUT_EN
  localparam int unsigned NB_TMO = $clog2(TIMEOUT_CYCLES + 1);
  logic [NB_TMO-1:0] tmo_cnt_q;
  logic              error_q;
  assign bus.o_error = error_q;
`else
  assign bus.o_error = 1'b0;
`endif

  // Byte offered to the UART by each sending state.
  always_comb begin
    tx_state_c  = 1'b1;
    send_byte_c = '0;
    case (state_q)
      TX_CMD:  send_byte_c = NB_BYTE'(CMD_LOAD);
      TX_LEN:  send_byte_c = NB_BYTE'(len_q);
      TX_WORD: send_byte_c = shreg_q[NB_DATA-1 -: NB_BYTE];
      TX_EXEC: send_byte_c = step_q ? NB_BYTE'(CMD_STEP) : NB_BYTE'(CMD_RUN);
      default: tx_state_c = 1'b0;
    endcase
  end

  assign tx_ack_c     = tx_state_c && tx_pend_q && bus.i_tx_done;
  assign sess_start_c = (state_q == IDLE) && bus.i_cmd_start;
  assign rx_byte_c    = (state_q == RX_DUMP) && bus.i_rx_done;
  assign wcnt_nxt_c   = word_cnt_q + NB_WCNT'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      step_q       <= 1'b0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      tx_pend_q    <= 1'b0;
      fetch_wait_q <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;

      // One start per byte; tx_done only counts while a byte is outstanding.
      if (tx_state_c && !tx_pend_q) begin
        tx_data_q  <= send_byte_c;
        tx_start_q <= 1'b1;
        tx_pend_q  <= 1'b1;
      end else if (tx_ack_c) begin
        tx_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.i_cmd_start) begin
            step_q     <= bus.i_cmd_step;
            len_q      <= bus.i_prog_len;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
            state_q    <= (bus.i_prog_len == '0) ? TX_EXEC : TX_CMD;
          end
        end
        TX_CMD: if (tx_ack_c) state_q <= TX_LEN;
        TX_LEN: begin
          if (tx_ack_c) begin
            fetch_wait_q <= 1'b1;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_wait_q) begin
            fetch_wait_q <= 1'b0;
          end else begin
            shreg_q    <= bus.i_prog_data;
            byte_cnt_q <= '0;
            state_q    <= TX_WORD;
          end
        end
        TX_WORD: begin
          if (tx_ack_c) begin
            shreg_q <= {shreg_q[NB_DATA-NB_BYTE-1:0], NB_BYTE'(0)};
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              word_cnt_q <= wcnt_nxt_c;
              if (wcnt_nxt_c < {1'b0, len_q}) begin
                fetch_wait_q <= 1'b1;
                state_q      <= FETCH;
              end else begin
                state_q <= TX_EXEC;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + NB_BCNT'(1);
            end
          end
        end
        TX_EXEC: begin
          if (tx_ack_c) begin
            state_q <= RX_DUMP;
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        RX_DUMP: begin
          if (word_valid_c && (word_idx_c == LAST_IDX)) begin
            state_q <= FINISH;
          end
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
          else if (rx_byte_c) begin
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q == NB_TMO'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            state_q <= FINISH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + NB_TMO'(1);
          end
`endif
        end
        FINISH: begin
          busy_q  <= 1'b0;
`ifdef DEBUG_HOST_RX_TIMEOUT_EN
          done_q  <= !error_q;
`else
          done_q  <= 1'b1;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  debug_word_deser #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE),
    .NB_IDX  (8)
  ) u_deser (
    .clk          (i_clock),
    .rst_n        (i_reset),
    .clr_i        (sess_start_c),
    .byte_valid_i (rx_byte_c),
    .byte_i       (bus.i_rx_data),
    .word_o       (bus.o_word),
    .word_valid_o (word_valid_c),
    .word_idx_o   (word_idx_c)
  );

  assign bus.o_prog_addr  = word_cnt_q[NB_ADDR-1:0];
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_word_valid = word_valid_c;
  assign bus.o_word_idx   = word_idx_c;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_debug_host_master.sv
// Directed bench for debug_host_master: UART tx responder, sync program ROM, dump feeder.
module tb_debug_host_master;

  localparam int unsigned NB_DATA    = 32;
  localparam int unsigned NB_BYTE    = 8;
  localparam int unsigned NB_ADDR    = 8;
  localparam int unsigned N_REGS     = 32;
  localparam int unsigned N_DM_WORDS = 16;
  localparam int unsigned N_DUMP     = 1 + N_REGS + N_DM_WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_host_master_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR)) bus ();

  debug_host_master #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR),
    .N_REGS(N_REGS), .N_DM_WORDS(N_DM_WORDS)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [256];
  logic [7:0]  tx_log [$];
  logic [31:0] word_log [$];
  logic [7:0]  idx_log [$];
  int          done_cnt  = 0;
  int          proto_viol = 0;

  // Synchronous program source: data follows the address by one cycle.
  always @(posedge clk) bus.i_prog_data <= rom[bus.o_prog_addr];

  // UART tx: log each started byte, answer with tx_done three cycles later.
  initial begin : tx_uart
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_tx_start) begin
        tx_log.push_back(bus.o_tx_data);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (rst_n && (bus.o_tx_start || bus.o_tx_data !== tx_log[$])) proto_viol++;
        end
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.o_word_valid) begin
      word_log.push_back(bus.o_word);
      idx_log.push_back(bus.o_word_idx);
    end
    if (bus.o_done) done_cnt++;
  end

  function automatic logic [31:0] dump_word(input int k);
    if (k == 0) return 32'h0000_0010;
    return {8'(k), 8'hA5, 8'(k * 3), 8'h3C};
  endfunction

  function automatic logic [31:0] rom_word(input int i);
    return {8'(i), 8'(255 - i), 8'(i ^ 90), 8'h96};
  endfunction

  task automatic clear_logs();
    tx_log.delete();
    word_log.delete();
    idx_log.delete();
    done_cnt   = 0;
    proto_viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_session(input logic step, input logic [NB_ADDR-1:0] len);
    @(negedge clk);
    bus.i_cmd_step  = step;
    bus.i_prog_len  = len;
    bus.i_cmd_start = 1'b1;
    @(negedge clk);
    bus.i_cmd_start = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    int c = 0;
    while (tx_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (tx_log.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (bus.o_busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = !bus.o_busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_words(input int first);
    logic [31:0] w;
    for (int k = first; k < N_DUMP; k++) begin
      w = dump_word(k);
      for (int b = 0; b < 4; b++) send_rx(w[31-8*b -: 8]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.o_busy, bus.o_tx_start, bus.o_word_valid, bus.o_done, bus.o_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.o_busy, bus.o_tx_start, bus.o_word_valid, bus.o_done, bus.o_error});
    end
    checks++;
    if ({bus.o_tx_data, bus.o_prog_addr, bus.o_word_idx} !== 24'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h, required 000000",
               {bus.o_tx_data, bus.o_prog_addr, bus.o_word_idx});
    end
    checks++;
    if (bus.o_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_word: got %h, required 00000000", bus.o_word);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_run();
    logic [7:0] exp [11] = '{8'h4C, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h52};
    bit ok;
    logic [31:0] w;
    clear_logs();
    rom[0] = 32'h1122_3344;
    rom[1] = 32'hAABB_CCDD;
    start_session(1'b0, 8'd2);
    wait_tx(11, 300, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || tx_log.size() != 11) begin
      errors++;
      $display("FAIL load_run_count: got %0d tx bytes, required 11", tx_log.size());
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp[i]) begin
        errors++;
        $display("FAIL load_run_byte%0d: got %h, required %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (proto_viol != 0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL load_run_proto: violations %0d busy %b, required 0 and 1",
               proto_viol, bus.o_busy);
    end
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h10);
    checks++;
    if (bus.o_word_valid !== 1'b1 || bus.o_word !== 32'h10 || bus.o_word_idx !== 8'd0) begin
      errors++;
      $display("FAIL first_word: got valid %b word %h idx %0d, required 1 00000010 0",
               bus.o_word_valid, bus.o_word, bus.o_word_idx);
    end
    send_words(1);
    wait_idle(50, ok);
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++;
      $display("FAIL dump_done: got busy %b done pulses %0d, required 0 and 1", bus.o_busy, done_cnt);
    end
    checks++;
    if (word_log.size() != N_DUMP) begin
      errors++;
      $display("FAIL dump_count: got %0d words, required %0d", word_log.size(), N_DUMP);
    end
    for (int k = 0; k < N_DUMP && k < word_log.size(); k++) begin
      w = dump_word(k);
      checks++;
      if (word_log[k] !== w || idx_log[k] !== 8'(k)) begin
        errors++;
        $display("FAIL dump_word%0d: got %h idx %0d, required %h idx %0d",
                 k, word_log[k], idx_log[k], w, k);
      end
    end
  endtask

  task automatic test_len0_step();
    bit ok;
    clear_logs();
    @(negedge clk);
    send_rx(8'hEE);
    start_session(1'b1, 8'd0);
    wait_tx(1, 100, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || tx_log.size() != 1 || tx_log[0] !== 8'h53) begin
      errors++;
      $display("FAIL len0_step: got %0d bytes first %h, required 1 byte 53",
               tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
    end
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_log.size() != 1) begin
      errors++;
      $display("FAIL stray_tx_done: got %0d bytes, required 1", tx_log.size());
    end
    send_words(0);
    wait_idle(50, ok);
    checks++;
    if (!ok || done_cnt != 1 || word_log.size() != N_DUMP) begin
      errors++;
      $display("FAIL len0_dump: got done %0d words %0d, required 1 and %0d",
               done_cnt, word_log.size(), N_DUMP);
    end
    checks++;
    if (word_log.size() == 0 || word_log[0] !== 32'h10) begin
      errors++;
      $display("FAIL idle_rx_discard: got first word %h, required 00000010",
               (word_log.size() > 0) ? word_log[0] : 32'hx);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp [7] = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h53};
    bit ok;
    clear_logs();
    rom[0] = 32'h1122_3344;
    start_session(1'b1, 8'd1);
    wait_tx(3, 100, ok);
    bus.i_cmd_step  = 1'b0;
    bus.i_prog_len  = 8'd5;
    bus.i_cmd_start = 1'b1;
    bus.i_rx_data   = 8'h99;
    bus.i_rx_done   = 1'b1;
    @(negedge clk);
    bus.i_cmd_start = 1'b0;
    bus.i_rx_done   = 1'b0;
    wait_tx(7, 200, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || tx_log.size() != 7 || word_log.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore_count: got %0d bytes %0d words, required 7 and 0",
               tx_log.size(), word_log.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== exp[i]) begin
        errors++;
        $display("FAIL busy_ignore_byte%0d: got %h, required %h", i,
                 (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp[i]);
      end
    end
    send_words(0);
    wait_idle(50, ok);
    checks++;
    if (!ok || done_cnt != 1 || word_log.size() != N_DUMP ||
        (word_log.size() > 0 && word_log[0] !== 32'h10)) begin
      errors++;
      $display("FAIL busy_ignore_dump: got done %0d words %0d, required 1 and %0d",
               done_cnt, word_log.size(), N_DUMP);
    end
  endtask

  task automatic test_max_len();
    logic [7:0]  exp_q [$];
    logic [31:0] w;
    bit ok;
    clear_logs();
    for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 255; i++) begin
      w = rom_word(i);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    end
    exp_q.push_back(8'h52);
    start_session(1'b0, 8'd255);
    wait_tx(exp_q.size(), 20000, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || tx_log.size() != exp_q.size() || proto_viol != 0) begin
      errors++;
      $display("FAIL max_len_count: got %0d bytes violations %0d, required %0d and 0",
               tx_log.size(), proto_viol, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL max_len_byte%0d: got %h, required %h", i, tx_log[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    rom[0] = 32'h1122_3344;
    rom[1] = 32'hAABB_CCDD;
    start_session(1'b0, 8'd2);
    wait_tx(4, 200, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_tx_start, bus.o_word_valid, bus.o_done, bus.o_error} !== 5'b0 ||
        {bus.o_tx_data, bus.o_prog_addr, bus.o_word_idx} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got flags %b fields %h, required 0",
               {bus.o_busy, bus.o_tx_start, bus.o_word_valid, bus.o_done, bus.o_error},
               {bus.o_tx_data, bus.o_prog_addr, bus.o_word_idx});
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || tx_log.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d bytes, required 4", tx_log.size());
    end
    clear_logs();
    start_session(1'b0, 8'd2);
    wait_tx(11, 300, ok);
    checks++;
    if (!ok || tx_log[0] !== 8'h4C || tx_log[1] !== 8'h02 || tx_log[10] !== 8'h52) begin
      errors++;
      $display("FAIL reset_mid_restart: got %0d bytes, required 11 starting 4C 02 ending 52",
               tx_log.size());
    end
    do_reset();
  endtask

  initial begin
    bus.i_cmd_start = 1'b0;
    bus.i_cmd_step  = 1'b0;
    bus.i_prog_len  = '0;
    bus.i_tx_done   = 1'b0;
    bus.i_rx_data   = '0;
    bus.i_rx_done   = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;

    test_reset();
    test_load_run();
    test_len0_step();
    test_ignore_busy();
    test_max_len();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
